divider_rate_ctrl: RTL and testbench
====================================

Name: divider_rate_ctrl

Overview:
Run-time controller for the lab's clock-divider datapath. It owns the divide counter and sequences it through idle, free-run and single-step operation. It accepts new terminal-count values over a valid/ready handshake and applies them only at period boundaries, so the divided clock never produces a runt phase. It drives the divided clock (clk_out) and a one-cycle tick enable for downstream lab logic such as display multiplexers and FSM step clocks.

Parameters:
WIDTH, 26, width of counter, terminal-count registers and cfg_count
DEFAULT_COUNT, 100, terminal count loaded at reset; tick period = DEFAULT_COUNT+1 cycles

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
start  input  1  level, sampled each edge: enter/continue free-run
stop  input  1  level: return to IDLE; highest priority
step  input  1  level: from IDLE, run exactly one period
cfg_valid  input  1  new terminal count offered
cfg_count  input  WIDTH  terminal count N (tick period N+1, clk_out period 2(N+1))
cfg_ready  output  1  controller can accept a config
tick  output  1  registered one-cycle pulse at each period end
clk_out  output  1  registered divided clock, toggles at each period end
running  output  1  high when state != IDLE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, count=0, active=DEFAULT_COUNT, pending_valid=0, tick=0, clk_out=0, running=0, cfg_ready=1. Any pending config is discarded.
- States: IDLE (counter held at 0), RUN, STEP.
- Command priority per edge: stop > start > step.
- IDLE transitions:
  - start -> RUN, count=0.
  - step (no start) -> STEP, count=0.
- RUN transitions:
  - stop -> IDLE, count=0, clk_out holds its level, tick=0.
  - start/step otherwise ignored.
- STEP transitions:
  - stop -> IDLE.
  - start -> RUN without clearing count.
  - At the period end -> IDLE.
- Counting (RUN/STEP): if count==active then count<=0, clk_out<=~clk_out, tick<=1; else count<=count+1, tick<=0. tick is 0 in every other cycle and state.
- Latency:
  - start sampled at edge k: running=1 after edge k; first tick high after edge k+active+1.
  - Subsequent ticks every active+1 cycles.
- Config handshake:
  - Transfer occurs on an edge with cfg_valid&&cfg_ready: pending<=cfg_count, pending_valid<=1; cfg_ready=!pending_valid (registered), so it drops after the accepting edge.
  - Apply in IDLE: active<=pending on the next edge.
  - Apply in RUN/STEP: apply on the edge where count==active (the same edge that emits tick). The new period starts from count 0.
  - cfg_ready re-asserts after the applying edge.
  - cfg_valid while cfg_ready=0 is ignored; the source holds it.
- Width and values:
  - cfg_count=0 is legal: tick every cycle, clk_out toggles every cycle.
  - Max value 2^WIDTH-1; count never exceeds active because active changes only when count returns to 0.
- Simultaneous events:
  - stop on the terminal edge: IDLE wins, no tick, no toggle; a pending config still applies (IDLE rule).
  - Config accepted on the terminal edge: applied at the next boundary, not the current one.
- rst low mid-operation overrides everything in the same edge.

Test Plan:
All tests use WIDTH=8, DEFAULT_COUNT=3.
1. Release rst, hold start from edge 0 -> running=1 after edge 0; tick high after edges 4, 8, 12; clk_out 0->1 at edge 4, 1->0 at edge 8 (period 8).
2. In RUN at count=1, offer cfg_count=1 -> cfg_ready low from the next cycle; current period still ends at count 3 with tick; then ticks every 2 cycles; cfg_ready high again after that boundary edge.
3. In IDLE, pulse step for one cycle -> running high for 4 cycles, exactly one tick, clk_out toggles once, then IDLE with count=0.
4. In RUN at count=2, assert stop and start together -> IDLE next edge, count=0, no tick, clk_out unchanged, running=0.
5. In RUN with a pending config (cfg_count=7), drive rst=0 for one edge -> all outputs at reset values, active=3, cfg_ready=1; restart shows a period of 4.
6. cfg_count=0 applied in IDLE, then start -> tick high every cycle, clk_out toggles every edge; stop returns to IDLE on the next edge.

Source files
------------

// File: rtl/divider_rate_ctrl.sv
// divider_rate_ctrl: divide counter sequencer (idle/free-run/single-step) with
// boundary-synchronised terminal-count updates, divided clock and tick outputs.
module divider_rate_ctrl #(
  parameter int WIDTH         = 26,
  parameter int DEFAULT_COUNT = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_count,
  output logic             cfg_ready,
  output logic             tick,
  output logic             clk_out,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count, count_n, active, active_n, pending, pending_n;
  logic pending_valid, pending_valid_n, tick_n, clk_out_n, term, apply;
  assign term      = state != IDLE && count == active;
  // a stop on the terminal edge defers the update to the following idle edge
  assign apply     = pending_valid && (state == IDLE || (term && !stop));
  assign cfg_ready = !pending_valid;
  assign running   = state != IDLE;
  always_comb begin
    state_n         = state;
    count_n         = '0;
    tick_n          = 1'b0;
    clk_out_n       = clk_out;
    active_n        = apply ? pending : active;
    pending_n       = pending;
    pending_valid_n = apply ? 1'b0 : pending_valid;
    if (cfg_valid && cfg_ready) begin
      pending_n       = cfg_count;
      pending_valid_n = 1'b1;
    end
    case (state)
      IDLE: state_n = stop ? IDLE : start ? RUN : step ? STEP : IDLE;
      default:
        if (stop) state_n = IDLE;
        else begin
          count_n   = term ? '0 : count + 1'b1;
          tick_n    = term;
          clk_out_n = term ? ~clk_out : clk_out;
          state_n   = start ? RUN : (state == STEP && term) ? IDLE : state;
        end
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      active        <= WIDTH'(DEFAULT_COUNT);
      pending       <= '0;
      pending_valid <= 1'b0;
      tick          <= 1'b0;
      clk_out       <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      active        <= active_n;
      pending       <= pending_n;
      pending_valid <= pending_valid_n;
      tick          <= tick_n;
      clk_out       <= clk_out_n;
    end
  end
endmodule

// File: tb/tb_divider_rate_ctrl.sv
// tb_divider_rate_ctrl: directed stimulus; expected ticks queued and checked by a monitor.
module tb_divider_rate_ctrl;
  logic clk_in = 1'b0;
  logic rst, start, stop, step, cfg_valid;
  logic [7:0] cfg_count;
  logic cfg_ready, tick, clk_out, running;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int at; logic clk; logic run; logic rdy;} exp_t;
  exp_t sb[$];

  divider_rate_ctrl #(.WIDTH(8), .DEFAULT_COUNT(3)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .step(step),
    .cfg_valid(cfg_valid), .cfg_count(cfg_count), .cfg_ready(cfg_ready),
    .tick(tick), .clk_out(clk_out), .running(running)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every tick must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (tick) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.at != cyc || e.clk !== clk_out || e.run !== running || e.rdy !== cfg_ready) begin
          errors++;
          $display("FAIL tick: got cyc=%0d clk_out=%b running=%b cfg_ready=%b, want cyc=%0d clk_out=%b running=%b cfg_ready=%b",
                   cyc, clk_out, running, cfg_ready, e.at, e.clk, e.run, e.rdy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic c, input logic r, input logic y);
    exp_t e;
    e.at = at; e.clk = c; e.run = r; e.rdy = y;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; cfg_valid = 1'b0; cfg_count = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    // free run, then a mid-period config change to period 2, then stop on a terminal edge
    t = cyc; rst = 1'b1; start = 1'b1;
    push(t+5, 1, 1, 1); push(t+9, 0, 1, 1); push(t+13, 1, 1, 1); push(t+17, 0, 1, 1);
    push(t+19, 1, 1, 1); push(t+21, 0, 1, 1); push(t+23, 1, 1, 1);
    wait_to(t+1);  chk("run_after_start", 32'(running), 1);
    wait_to(t+14); cfg_valid = 1'b1; cfg_count = 8'd1;
    wait_to(t+15); chk("rdy_low_after_accept", 32'(cfg_ready), 0); cfg_valid = 1'b0;
    wait_to(t+16); chk("rdy_low_pending", 32'(cfg_ready), 0);
    wait_to(t+24); stop = 1'b1;
    wait_to(t+25);
    chk("stop_term_running", 32'(running), 0);
    chk("stop_term_clk_out", 32'(clk_out), 1);
    chk("stop_term_tick", 32'(tick), 0);
    stop = 1'b0; start = 1'b0; cfg_valid = 1'b1; cfg_count = 8'd3;
    wait_to(t+26); cfg_valid = 1'b0; chk("idle_rdy_low", 32'(cfg_ready), 0);
    wait_to(t+27); chk("idle_rdy_back", 32'(cfg_ready), 1);
    // single step
    t = cyc; step = 1'b1;
    push(t+5, 0, 0, 1);
    wait_to(t+1); step = 1'b0; chk("step_running", 32'(running), 1);
    wait_to(t+4); chk("step_running_end", 32'(running), 1);
    wait_to(t+5); chk("step_idle", 32'(running), 0); chk("step_count", 32'(dut.count), 0);
    wait_to(t+8);
    // stop and start together mid-period
    t = cyc; start = 1'b1;
    wait_to(t+3); stop = 1'b1;
    wait_to(t+4);
    chk("stop_running", 32'(running), 0);
    chk("stop_clk_out", 32'(clk_out), 0);
    chk("stop_tick", 32'(tick), 0);
    chk("stop_count", 32'(dut.count), 0);
    stop = 1'b0; start = 1'b0;
    wait_to(t+6);
    // reset with a pending config discards it
    t = cyc; start = 1'b1;
    push(t+5, 1, 1, 1);
    wait_to(t+6); cfg_valid = 1'b1; cfg_count = 8'd7;
    wait_to(t+7); cfg_valid = 1'b0; chk("pend_rdy_low", 32'(cfg_ready), 0);
    wait_to(t+8); rst = 1'b0;
    wait_to(t+9);
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_clk_out", 32'(clk_out), 0);
    chk("mid_rst_running", 32'(running), 0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 1);
    chk("mid_rst_active", 32'(dut.active), 3);
    rst = 1'b1;
    push(t+14, 1, 1, 1); push(t+18, 0, 1, 1);
    wait_to(t+18); start = 1'b0; stop = 1'b1;
    wait_to(t+19); stop = 1'b0; chk("restart_stop", 32'(running), 0);
    // terminal count 0: tick every cycle
    t = cyc; cfg_valid = 1'b1; cfg_count = 8'd0;
    wait_to(t+1); cfg_valid = 1'b0;
    wait_to(t+2); start = 1'b1;
    push(t+4, 1, 1, 1); push(t+5, 0, 1, 1); push(t+6, 1, 1, 1);
    wait_to(t+6); start = 1'b0; stop = 1'b1;
    wait_to(t+7);
    chk("zero_stop_running", 32'(running), 0);
    chk("zero_stop_clk_out", 32'(clk_out), 1);
    chk("zero_stop_tick", 32'(tick), 0);
    stop = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("ticks_outstanding", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
